// File: rtl/sha3_block_loader_if.sv
// sha3_block_loader_if: message word stream in, rate block stream out.
interface sha3_block_loader_if;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [1087:0] blk_data;
  logic          blk_first;
  logic          blk_last;
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha3_block_loader.sv
// sha3_block_loader: packs 64-bit message words into SHA3-256 rate blocks with pad10*1 (suffix 0x06).
module sha3_block_loader (
  input logic clk,
  input logic rst_n,
  sha3_block_loader_if.slave bus
);
  localparam int RATE = 1088;
  localparam int WORDS = 17;
  localparam int RATE_BYTES = 136;
  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;
  state_t state, state_d;
  logic [4:0] cnt, cnt_d;
  logic [RATE-1:0] buf_q, buf_d;
  logic first, first_d, last, last_d, pad, pad_d;
  logic [3:0] n;
  logic [7:0] p;
  logic [63:0] word;
  logic [10:0] lane_idx, pad_idx;
  assign n = bus.in_bytes > 4'd8 ? 4'd8 : bus.in_bytes;
  assign p = {cnt, 3'b000} + {4'b0000, n};
  assign word = n == 4'd8 ? bus.in_data : bus.in_data & ((64'd1 << {n, 3'b000}) - 64'd1);
  assign lane_idx = {cnt, 6'b000000};
  assign pad_idx = {p, 3'b000};
  assign bus.in_ready = state == FILL;
  assign bus.blk_valid = state == EMIT;
  assign bus.blk_data = buf_q;
  assign bus.blk_first = first;
  assign bus.blk_last = last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt <= '0;
      buf_q <= '0;
      first <= 1'b1;
      last <= 1'b0;
      pad <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      buf_q <= buf_d;
      first <= first_d;
      last <= last_d;
      pad <= pad_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    buf_d = buf_q;
    first_d = first;
    last_d = last;
    pad_d = pad;
    case (state)
      FILL: if (bus.in_valid) begin
        cnt_d = cnt + 5'd1;
        buf_d[lane_idx +: 64] = bus.in_last ? word : bus.in_data;
        if (bus.in_last || cnt == 5'(WORDS - 1)) begin
          cnt_d = '0;
          state_d = EMIT;
          last_d = 1'b0;
        end
        // A message ending exactly on a block boundary needs a separate pad-only block
        if (bus.in_last && p == 8'(RATE_BYTES)) pad_d = 1'b1;
        else if (bus.in_last) begin
          last_d = 1'b1;
          buf_d[pad_idx +: 8] = buf_d[pad_idx +: 8] ^ 8'h06;
          buf_d[RATE-1 -: 8] = buf_d[RATE-1 -: 8] ^ 8'h80;
        end
      end
      EMIT: if (bus.blk_ready) begin
        buf_d = '0;
        last_d = 1'b0;
        first_d = last;
        state_d = pad ? PADBLK : FILL;
      end
      PADBLK: begin
        buf_d = '0;
        buf_d[7:0] = 8'h06;
        buf_d[RATE-1 -: 8] = 8'h80;
        state_d = EMIT;
        last_d = 1'b1;
        first_d = 1'b0;
        pad_d = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end
endmodule

// File: tb/tb_sha3_block_loader.sv
// tb_sha3_block_loader: scoreboard bench comparing emitted rate blocks against a byte-level pad10*1 model.
module tb_sha3_block_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  sha3_block_loader_if bus();
  sha3_block_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [1087:0] d;
    logic f;
    logic l;
  } blk_t;
  blk_t q[$];
  int checks = 0;
  int failures = 0;
  int nblk = 0;
  logic [7:0] msg [0:271];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference: whole message padded to a multiple of 136 bytes, then split into blocks
  task automatic expect_msg(int len);
    int nb;
    logic [7:0] pb [0:271];
    blk_t e;
    nb = len / 136 + 1;
    for (int i = 0; i < nb * 136; i++) pb[i] = i < len ? msg[i] : 8'h00;
    pb[len] = pb[len] ^ 8'h06;
    pb[nb*136-1] = pb[nb*136-1] ^ 8'h80;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 136; k++) e.d[8*k +: 8] = pb[b*136+k];
      e.f = b == 0;
      e.l = b == nb - 1;
      q.push_back(e);
    end
  endtask
  task automatic drive_word(logic [63:0] d, logic lst, logic [3:0] nbytes);
    int t = 0;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = lst;
    bus.in_bytes = nbytes;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic send_msg(int len);
    int nw;
    logic [63:0] d;
    expect_msg(len);
    nw = len == 0 ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int k = 0; k < 8; k++) if (w*8 + k < len) d[8*k +: 8] = msg[w*8+k];
      drive_word(d, w == nw - 1, w == nw - 1 ? 4'(len - w*8) : 4'd8);
    end
    chk("latency_valid", 64'(bus.blk_valid), 64'd1);
  endtask
  task automatic fill_pattern(int len, int seed);
    for (int i = 0; i < len; i++) msg[i] = 8'(i * 7 + seed);
  endtask
  initial begin : monitor
    logic held = 1'b0;
    logic [1087:0] prev = '0;
    blk_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.blk_valid) begin
        chk("in_ready_low", 64'(bus.in_ready), 64'd0);
        if (held) chk("blk_stable", 64'(bus.blk_data == prev), 64'd1);
        prev = bus.blk_data;
        held = !bus.blk_ready;
        if (bus.blk_ready) begin
          if (q.size() == 0) chk("unexpected_blk", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            for (int i = 0; i < 17; i++)
              chk($sformatf("blk%0d_lane%0d", nblk, i), bus.blk_data[64*i +: 64], e.d[64*i +: 64]);
            chk($sformatf("blk%0d_first", nblk), 64'(bus.blk_first), 64'(e.f));
            chk($sformatf("blk%0d_last", nblk), 64'(bus.blk_last), 64'(e.l));
          end
          nblk++;
        end
      end else held = 1'b0;
    end
  end
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_blk_valid"}, 64'(bus.blk_valid), 64'd0);
    chk({tag, "_blk_first"}, 64'(bus.blk_first), 64'd1);
    chk({tag, "_blk_last"}, 64'(bus.blk_last), 64'd0);
    chk({tag, "_blk_data"}, 64'(|bus.blk_data), 64'd0);
  endtask
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_bytes = '0;
    bus.blk_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10 chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_msg(0);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    fill_pattern(135, 3);
    send_msg(135);
    fill_pattern(136, 11);
    send_msg(136);
    @(posedge clk);
    #1 chk("padblk_gap", 64'(bus.blk_valid), 64'd0);
    @(posedge clk);
    #1 chk("padblk_valid", 64'(bus.blk_valid), 64'd1);
    chk("padblk_first", 64'(bus.blk_first), 64'd0);
    chk("padblk_last", 64'(bus.blk_last), 64'd1);
    @(posedge clk);
    #1 fill_pattern(200, 29);
    bus.blk_ready = 1'b0;
    fork
      send_msg(200);
      begin
        t = 0;
        while (!bus.blk_valid && t < 100) begin
          @(posedge clk);
          #1 t++;
        end
        if (!bus.blk_valid) chk("bp_wait_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1 bus.blk_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1 fill_pattern(72, 5);
    for (int w = 0; w < 9; w++) drive_word({msg[w*8+7], msg[w*8+6], msg[w*8+5], msg[w*8+4],
                                            msg[w*8+3], msg[w*8+2], msg[w*8+1], msg[w*8]}, 1'b0, 4'd8);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midfill_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
